// File: rtl/pipe_pkg.sv
// Shared types and stage widths for the five-stage core's inter-stage registers.
// - pipe_state_t : occupancy of a pipe_stage_reg (EMPTY / BUSY / FULL)
// - *_CTRL_W / *_DATA_W : control and datapath field widths per stage boundary
// - stage_state() : derives the occupancy state from the two slot valid bits
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_t;

  // ID/EX: RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[3:0], ALUSrc
  localparam int ID_EX_CTRL_W  = 11;
  // ID/EX: RD1, RD2, PC, imm, PCPlus4 (5 x 32) + Rs1, Rs2, Rd (3 x 5) + funct3
  localparam int ID_EX_DATA_W  = 178;
  // EX/MEM: RegWrite, ResultSrc[1:0], MemWrite
  localparam int EX_MEM_CTRL_W = 4;
  // EX/MEM: ALUResult, WriteData, PCPlus4 (3 x 32) + Rd + funct3
  localparam int EX_MEM_DATA_W = 104;
  // MEM/WB: RegWrite, ResultSrc[1:0]
  localparam int MEM_WB_CTRL_W = 3;
  // MEM/WB: ALUResult, ReadData, PCPlus4 (3 x 32) + Rd
  localparam int MEM_WB_DATA_W = 101;

  function automatic pipe_state_t stage_state(input logic main_vld, input logic skid_vld);
    if (skid_vld) return ST_FULL;
    if (main_vld) return ST_BUSY;
    return ST_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: valid bit, control field, datapath field.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (clears everything)
//   load           : capture in_ctrl/in_data and mark the entry valid
//   clear          : invalidate the entry; has priority over load
//   in_ctrl/in_data: value captured on load
//   valid/ctrl/data: stored entry
// The control field is zeroed in storage whenever the entry becomes invalid, so a
// bubble never carries stale control bits. The datapath field is held on clear.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : squash every held beat (and any beat offered this cycle)
//   in_valid/in_ready   : upstream handshake; in_ctrl/in_data upstream payload
//   out_valid/out_ready : downstream handshake; out_ctrl/out_data payload
//   full                : skid entry occupied (always 0 when SKID=0)
// SKID=1: main + skid entries, in_ready depends only on registered state.
// SKID=0: main entry only, in_ready looks through to out_ready.
// out_ctrl is zero whenever out_valid is 0; out_data holds its last value.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              full
);

  logic              main_vld_p0;
  logic [CTRL_W-1:0] main_ctrl_p0;
  logic [DATA_W-1:0] main_data_p0;
  logic              skid_vld_p0;
  logic [CTRL_W-1:0] skid_ctrl_p0;
  logic [DATA_W-1:0] skid_data_p0;

  logic              in_fire;
  logic              out_fire;
  logic              main_load;
  logic              main_clear;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clear;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  pipe_state_t       state;

  assign state = stage_state(main_vld_p0, skid_vld_p0);

  always_comb begin
    in_ready = 1'b0;
    if (SKID) in_ready = !skid_vld_p0 && !reset;
    else      in_ready = (out_ready || !main_vld_p0) && !reset;
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_vld_p0 && out_ready;

  // Next-state decode. Flush wins over every handshake; a beat offered in the
  // flush cycle is simply not loaded. With SKID=0 a BUSY stage only accepts when
  // out_ready is high, so the skid branch is never taken.
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = in_fire;
        ST_BUSY: begin
          if (in_fire && out_fire) main_load  = 1'b1;
          else if (in_fire)        skid_load  = 1'b1;
          else if (out_fire)       main_clear = 1'b1;
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl_p0 : in_ctrl;
  assign main_data_d = main_from_skid ? skid_data_p0 : in_data;

  // Stage boundary: main entry drives the outputs
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .reset   (reset),
    .load    (main_load),
    .clear   (main_clear),
    .in_ctrl (main_ctrl_d),
    .in_data (main_data_d),
    .valid   (main_vld_p0),
    .ctrl    (main_ctrl_p0),
    .data    (main_data_p0)
  );

  if (SKID) begin : g_skid
    // Stage boundary: skid entry catches the beat accepted while downstream stalls
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk     (clk),
      .reset   (reset),
      .load    (skid_load),
      .clear   (skid_clear),
      .in_ctrl (in_ctrl),
      .in_data (in_data),
      .valid   (skid_vld_p0),
      .ctrl    (skid_ctrl_p0),
      .data    (skid_data_p0)
    );
  end else begin : g_noskid
    logic unused_skid;
    assign skid_vld_p0  = 1'b0;
    assign skid_ctrl_p0 = '0;
    assign skid_data_p0 = '0;
    assign unused_skid  = skid_load | skid_clear;
  end

  assign out_valid = main_vld_p0;
  assign out_ctrl  = main_ctrl_p0;
  assign out_data  = main_data_p0;
  assign full      = skid_vld_p0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  localparam int CW = 11;
  localparam int DW = 178;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          u1_in_ready, u1_out_valid, u1_full;
  logic [CW-1:0] u1_out_ctrl;
  logic [DW-1:0] u1_out_data;
  logic          u0_in_ready, u0_out_valid, u0_full;
  logic [CW-1:0] u0_out_ctrl;
  logic [DW-1:0] u0_out_data;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: FIFO of held beats per stage, plus last datapath value shown
  beat_t         q1[$];
  beat_t         q0[$];
  logic [DW-1:0] h1, h0;
  bit            started = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(u1_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u1_out_valid), .out_ready(out_ready),
    .out_ctrl(u1_out_ctrl), .out_data(u1_out_data), .full(u1_full)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(u0_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(u0_out_valid), .out_ready(out_ready),
    .out_ctrl(u0_out_ctrl), .out_data(u0_out_data), .full(u0_full)
  );

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // Reference update: a capacity-2 FIFO (SKID=1) and capacity-1 FIFO (SKID=0)
  always @(posedge clk) begin
    beat_t b;
    bit    rdy, fin, fout;
    b.c = in_ctrl;
    b.d = in_data;
    if (reset) begin
      q1.delete();
      q0.delete();
      h1 = '0;
      h0 = '0;
      started = 1'b1;
    end else begin
      rdy  = q1.size() < 2;
      fin  = in_valid && rdy;
      fout = (q1.size() > 0) && out_ready;
      if (q1.size() > 0) h1 = q1[0].d;
      if (flush) q1.delete();
      else begin
        if (fout) void'(q1.pop_front());
        if (fin)  q1.push_back(b);
      end

      rdy  = out_ready || (q0.size() == 0);
      fin  = in_valid && rdy;
      fout = (q0.size() > 0) && out_ready;
      if (q0.size() > 0) h0 = q0[0].d;
      if (flush) q0.delete();
      else begin
        if (fout) void'(q0.pop_front());
        if (fin)  q0.push_back(b);
      end
    end
  end

  // Every-cycle comparison of both stages against the reference
  always @(negedge clk) begin
    if (started) begin
      chk("s1 out_valid", u1_out_valid, q1.size() > 0);
      chk("s1 out_ctrl",  u1_out_ctrl,  (q1.size() > 0) ? q1[0].c : '0);
      chk("s1 out_data",  u1_out_data,  (q1.size() > 0) ? q1[0].d : h1);
      chk("s1 in_ready",  u1_in_ready,  !reset && (q1.size() < 2));
      chk("s1 full",      u1_full,      q1.size() == 2);
      chk("s0 out_valid", u0_out_valid, q0.size() > 0);
      chk("s0 out_ctrl",  u0_out_ctrl,  (q0.size() > 0) ? q0[0].c : '0);
      chk("s0 out_data",  u0_out_data,  (q0.size() > 0) ? q0[0].d : h0);
      chk("s0 in_ready",  u0_in_ready,  !reset && (out_ready || q0.size() == 0));
      chk("s0 full",      u0_full,      1'b0);
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    step(); step();
    // reset state
    chk("rst out_valid", u1_out_valid, 0);
    chk("rst out_ctrl",  u1_out_ctrl, 0);
    chk("rst out_data",  u1_out_data, 0);
    chk("rst full",      u1_full, 0);
    chk("rst in_ready",  u1_in_ready, 0);
    reset = 1'b0;
    #1 chk("rst release in_ready", u1_in_ready, 1);
    step();

    // streaming 1..8 with ctrl 0x7FF
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_ctrl = 11'h7FF; in_data = DW'(i);
      #1 chk("stream in_ready", u1_in_ready, 1);
      step();
      chk("stream out_data", u1_out_data, i);
      chk("stream out_ctrl", u1_out_ctrl, 11'h7FF);
    end
    in_valid = 1'b0;
    step();
    chk("stream drained", u1_out_valid, 0);
    chk("model drained", q1.size(), 0);

    // stall into skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 11'h001; in_data = DW'(32'h11);
    step();
    in_ctrl = 11'h002; in_data = DW'(32'h22);
    step();
    in_valid = 1'b0;
    #1;
    chk("stall full", u1_full, 1);
    chk("stall in_ready", u1_in_ready, 0);
    chk("model holds two", q1.size(), 2);
    step();
    chk("stall out_data held", u1_out_data, 32'h11);
    chk("stall in_ready held", u1_in_ready, 0);
    out_ready = 1'b1;
    #1 chk("drain A", u1_out_data, 32'h11);
    step();
    chk("drain B", u1_out_data, 32'h22);
    chk("drain full cleared", u1_full, 0);
    step();
    chk("drain empty", u1_out_valid, 0);

    // flush while FULL, with C offered in the same cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 11'h00D; in_data = DW'(32'h33);
    step();
    in_ctrl = 11'h00E; in_data = DW'(32'h44);
    step();
    chk("pre-flush full", u1_full, 1);
    flush = 1'b1; in_ctrl = 11'h003; in_data = DW'(32'h55);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush out_valid", u1_out_valid, 0);
    chk("flush out_ctrl", u1_out_ctrl, 0);
    chk("flush full", u1_full, 0);
    chk("flush data held", u1_out_data, 32'h33);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush C dropped", u1_out_valid, 0);
    end

    // reset in the middle of a stalled stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 11'h0A0; in_data = DW'(32'h66);
    step();
    in_data = DW'(32'h77);
    step();
    chk("pre-reset full", u1_full, 1);
    reset = 1'b1;
    step();
    #1;
    chk("midrst out_valid", u1_out_valid, 0);
    chk("midrst out_ctrl", u1_out_ctrl, 0);
    chk("midrst out_data", u1_out_data, 0);
    chk("midrst full", u1_full, 0);
    chk("midrst in_ready", u1_in_ready, 0);
    reset = 1'b0; in_valid = 1'b0;
    #1 chk("midrst release in_ready", u1_in_ready, 1);
    step();

    // bubble control
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 11'h5A5; in_data = DW'(32'h99);
    step();
    in_valid = 1'b0;
    chk("bubble ctrl live", u1_out_ctrl, 11'h5A5);
    step();
    chk("bubble ctrl zero", u1_out_ctrl, 0);
    chk("bubble data held", u1_out_data, 32'h99);

    // SKID=0: out_ready toggling with continuous input
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2 == 0);
      in_valid = 1'b1; in_ctrl = 11'h100 + 11'(i); in_data = DW'(32'h100 + i);
      #1;
      if (u0_out_valid) chk("s0 in_ready mirrors out_ready", u0_in_ready, out_ready);
      chk("s0 full zero", u0_full, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 6 : 3));
      in_ctrl   = CW'($urandom);
      in_data   = rnd_data();
      step();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
